// File: rtl/wb_writeback_if.sv
// MEM-to-WB handshake bundle: MEM-stage instruction fields in, register-file write port out.
interface wb_writeback_if;
  logic        MEM_Valid;
  logic        MEM_RegWrite;
  logic        MEM_MemToReg;
  logic        MEM_JmpandLink;
  logic        MEM_Wide;
  logic [4:0]  MEM_DstReg;
  logic [4:0]  MEM_HiDstReg;
  logic [63:0] MEM_AluResult;
  logic [31:0] MEM_ReadData;
  logic [31:0] MEM_PC;
  logic        Flush;
  logic [4:0]  WB_DstReg;
  logic [63:0] WB_Data;
  logic        RegWrite;
  logic        MEM_WB_JmpandLink;
  logic        WB_Stall;

  // MEM stage side drives the instruction and observes the write port and stall.
  modport master (
    output MEM_Valid, MEM_RegWrite, MEM_MemToReg, MEM_JmpandLink, MEM_Wide,
           MEM_DstReg, MEM_HiDstReg, MEM_AluResult, MEM_ReadData, MEM_PC, Flush,
    input  WB_DstReg, WB_Data, RegWrite, MEM_WB_JmpandLink, WB_Stall
  );

  modport slave (
    input  MEM_Valid, MEM_RegWrite, MEM_MemToReg, MEM_JmpandLink, MEM_Wide,
           MEM_DstReg, MEM_HiDstReg, MEM_AluResult, MEM_ReadData, MEM_PC, Flush,
    output WB_DstReg, WB_Data, RegWrite, MEM_WB_JmpandLink, WB_Stall
  );
endinterface

// File: rtl/wb_writeback_ctrl.sv
// MEM/WB pipeline register and write-back sequencer; wide (64-bit) results are
// written as two consecutive 32-bit register writes with a one-cycle MEM stall.
module wb_writeback_ctrl #(
  parameter int unsigned LINK_OFFSET = 8,
  parameter int unsigned LINK_REG    = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_writeback_if.slave  bus
);

  localparam logic [31:0] link_offset_c = LINK_OFFSET[31:0];
  localparam logic [4:0]  link_reg_c    = LINK_REG[4:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ONE,
    S_LO,
    S_HI
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic        rw_q, rw_d;
  logic        jal_q, jal_d;
  logic [31:0] hi_word_q, hi_word_d;
  logic [4:0]  hi_dst_q, hi_dst_d;
  logic        hi_we_q, hi_we_d;

  // Next write presentation. While in S_LO the MEM stage is stalled, so the
  // offered instruction (and Flush) is ignored and the latched high word goes out.
  always_comb begin
    state_d   = S_IDLE;
    dst_d     = 5'd0;
    data_d    = 32'd0;
    rw_d      = 1'b0;
    jal_d     = 1'b0;
    hi_word_d = hi_word_q;
    hi_dst_d  = hi_dst_q;
    hi_we_d   = hi_we_q;

    if (state_q == S_LO) begin
      state_d = S_HI;
      dst_d   = hi_dst_q;
      data_d  = hi_word_q;
      rw_d    = hi_we_q && (hi_dst_q != 5'd0);
    end else if (bus.MEM_Valid && !bus.Flush) begin
      if (bus.MEM_JmpandLink) begin
        state_d = S_ONE;
        dst_d   = link_reg_c;
        data_d  = bus.MEM_PC + link_offset_c;
        rw_d    = 1'b1;
        jal_d   = 1'b1;
      end else if (bus.MEM_Wide) begin
        state_d   = S_LO;
        dst_d     = bus.MEM_DstReg;
        data_d    = bus.MEM_AluResult[31:0];
        rw_d      = bus.MEM_RegWrite && (bus.MEM_DstReg != 5'd0);
        hi_word_d = bus.MEM_AluResult[63:32];
        hi_dst_d  = bus.MEM_HiDstReg;
        hi_we_d   = bus.MEM_RegWrite;
      end else begin
        state_d = S_ONE;
        dst_d   = bus.MEM_DstReg;
        data_d  = bus.MEM_MemToReg ? bus.MEM_ReadData : bus.MEM_AluResult[31:0];
        rw_d    = bus.MEM_RegWrite && (bus.MEM_DstReg != 5'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dst_q     <= 5'd0;
      data_q    <= 32'd0;
      rw_q      <= 1'b0;
      jal_q     <= 1'b0;
      hi_word_q <= 32'd0;
      hi_dst_q  <= 5'd0;
      hi_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      jal_q     <= jal_d;
      hi_word_q <= hi_word_d;
      hi_dst_q  <= hi_dst_d;
      hi_we_q   <= hi_we_d;
    end
  end

  assign bus.WB_DstReg         = dst_q;
  assign bus.WB_Data           = {32'd0, data_q};
  assign bus.RegWrite          = rw_q;
  assign bus.MEM_WB_JmpandLink = jal_q;
  assign bus.WB_Stall          = (state_q == S_LO);

endmodule

// File: tb/tb_wb_writeback_ctrl.sv
// Directed bench for wb_writeback_ctrl: a queue-based write model checked every
// cycle, plus literal expectations for each scenario.
module tb_wb_writeback_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_writeback_if bus ();

  wb_writeback_ctrl #(.LINK_OFFSET(8), .LINK_REG(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int assert_count = 0;
  int fail_count   = 0;
  bit check_en     = 1'b0;

  typedef struct {
    logic [4:0]  dst;
    logic [63:0] data;
    logic        rw;
  } wr_t;

  wr_t owed[$];
  logic [4:0]  exp_dst      = '0;
  logic [63:0] exp_data     = '0;
  logic        exp_rw       = 1'b0;
  logic        exp_jal      = 1'b0;
  logic        exp_stall    = 1'b0;
  logic        exp_has_data = 1'b1;

  // Model: each captured instruction becomes one write, or two for a wide
  // result; the second is owed and blocks capture on the edge it is presented.
  always @(posedge clk or negedge rst_n) begin
    wr_t w;
    if (!rst_n) begin
      owed.delete();
      exp_dst <= '0; exp_data <= '0; exp_rw <= 1'b0;
      exp_jal <= 1'b0; exp_stall <= 1'b0; exp_has_data <= 1'b1;
    end else if (owed.size() > 0) begin
      w = owed.pop_front();
      exp_dst <= w.dst; exp_data <= w.data; exp_rw <= w.rw;
      exp_jal <= 1'b0; exp_stall <= 1'b0; exp_has_data <= 1'b1;
    end else if (bus.MEM_Valid && !bus.Flush) begin
      exp_has_data <= 1'b1;
      exp_jal      <= bus.MEM_JmpandLink;
      if (bus.MEM_JmpandLink) begin
        exp_dst   <= 5'd31;
        exp_data  <= {32'd0, bus.MEM_PC + 32'd8};
        exp_rw    <= 1'b1;
        exp_stall <= 1'b0;
      end else begin
        exp_dst  <= bus.MEM_DstReg;
        exp_rw   <= bus.MEM_RegWrite && (bus.MEM_DstReg != 0);
        exp_data <= (bus.MEM_MemToReg && !bus.MEM_Wide) ? {32'd0, bus.MEM_ReadData}
                                                        : {32'd0, bus.MEM_AluResult[31:0]};
        exp_stall <= bus.MEM_Wide;
        if (bus.MEM_Wide) begin
          w.dst  = bus.MEM_HiDstReg;
          w.data = {32'd0, bus.MEM_AluResult[63:32]};
          w.rw   = bus.MEM_RegWrite && (bus.MEM_HiDstReg != 0);
          owed.push_back(w);
        end
      end
    end else begin
      exp_rw <= 1'b0; exp_jal <= 1'b0; exp_stall <= 1'b0; exp_has_data <= 1'b0;
    end
  end

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      checkValue("model RegWrite", {63'd0, bus.RegWrite}, {63'd0, exp_rw});
      checkValue("model JmpandLink", {63'd0, bus.MEM_WB_JmpandLink}, {63'd0, exp_jal});
      checkValue("model WB_Stall", {63'd0, bus.WB_Stall}, {63'd0, exp_stall});
      if (exp_has_data) begin
        checkValue("model WB_DstReg", {59'd0, bus.WB_DstReg}, {59'd0, exp_dst});
        checkValue("model WB_Data", bus.WB_Data, exp_data);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [4:0] dst, input logic [63:0] data,
                             input logic rw, input logic jal, input logic stall, input bit chk_data);
    checkValue({name, " RegWrite"}, {63'd0, bus.RegWrite}, {63'd0, rw});
    checkValue({name, " JmpandLink"}, {63'd0, bus.MEM_WB_JmpandLink}, {63'd0, jal});
    checkValue({name, " WB_Stall"}, {63'd0, bus.WB_Stall}, {63'd0, stall});
    if (chk_data) begin
      checkValue({name, " WB_DstReg"}, {59'd0, bus.WB_DstReg}, {59'd0, dst});
      checkValue({name, " WB_Data"}, bus.WB_Data, data);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rw, input logic m2r,
                               input logic jal, input logic wide, input logic [4:0] dst,
                               input logic [4:0] hidst, input logic [63:0] alu,
                               input logic [31:0] rd, input logic [31:0] pc, input logic flush);
    bus.MEM_Valid      = valid;
    bus.MEM_RegWrite   = rw;
    bus.MEM_MemToReg   = m2r;
    bus.MEM_JmpandLink = jal;
    bus.MEM_Wide       = wide;
    bus.MEM_DstReg     = dst;
    bus.MEM_HiDstReg   = hidst;
    bus.MEM_AluResult  = alu;
    bus.MEM_ReadData   = rd;
    bus.MEM_PC         = pc;
    bus.Flush          = flush;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 64'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    checkOutput("reset", 5'd0, 64'd0, 0, 0, 0, 1);
    check_en = 1'b1;
    step();
    rst_n = 1'b1;

    // ALU single write, held one cycle only
    applyStimulus(1, 1, 0, 0, 0, 5'd5, 5'd0, 64'h1234_5678_9ABC_DEF0, 32'h0, 32'h0, 0);
    step();
    checkOutput("alu", 5'd5, 64'h0000_0000_9ABC_DEF0, 1, 0, 0, 1);
    idle();
    step();
    checkOutput("alu one cycle", 5'd0, 64'd0, 0, 0, 0, 0);

    // Load to r0: data driven, write suppressed
    applyStimulus(1, 1, 1, 0, 0, 5'd0, 5'd0, 64'h0, 32'hCAFE_F00D, 32'h0, 0);
    step();
    checkOutput("load r0", 5'd0, 64'h0000_0000_CAFE_F00D, 0, 0, 0, 1);

    // jal with MemToReg and Wide also set: link has priority
    applyStimulus(1, 1, 1, 1, 1, 5'd7, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1111_1111, 32'h0040_0010, 0);
    step();
    checkOutput("jal", 5'd31, 64'h0000_0000_0040_0018, 1, 1, 0, 1);

    // Wide write followed by a held ALU instruction
    applyStimulus(1, 1, 0, 0, 1, 5'd8, 5'd9, 64'hAAAA_0001_BBBB_0002, 32'h0, 32'h0, 0);
    step();
    checkOutput("wide lo", 5'd8, 64'h0000_0000_BBBB_0002, 1, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 5'd10, 5'd0, 64'h0000_0000_0000_0042, 32'h0, 32'h0, 0);
    step();
    checkOutput("wide hi", 5'd9, 64'h0000_0000_AAAA_0001, 1, 0, 0, 1);
    step();
    checkOutput("held after wide", 5'd10, 64'h0000_0000_0000_0042, 1, 0, 0, 1);

    // Flush kills the offered write
    applyStimulus(1, 1, 0, 0, 0, 5'd3, 5'd0, 64'h77, 32'h0, 32'h0, 1);
    step();
    checkOutput("flush", 5'd0, 64'd0, 0, 0, 0, 0);

    // Flush during S_LO does not cancel the high half
    applyStimulus(1, 1, 0, 0, 1, 5'd12, 5'd13, 64'h1111_2222_3333_4444, 32'h0, 32'h0, 0);
    step();
    checkOutput("wide2 lo", 5'd12, 64'h0000_0000_3333_4444, 1, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 5'd4, 5'd0, 64'h99, 32'h0, 32'h0, 1);
    step();
    checkOutput("wide2 hi under flush", 5'd13, 64'h0000_0000_1111_2222, 1, 0, 0, 1);
    step();
    checkOutput("flushed after wide", 5'd0, 64'd0, 0, 0, 0, 0);

    // Wide with high destination r0: only the high half is suppressed
    applyStimulus(1, 1, 0, 0, 1, 5'd14, 5'd0, 64'hDEAD_BEEF_0000_0001, 32'h0, 32'h0, 0);
    step();
    checkOutput("wide3 lo", 5'd14, 64'h0000_0000_0000_0001, 1, 0, 1, 1);
    idle();
    step();
    checkOutput("wide3 hi r0", 5'd0, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 1);

    // Link address wraps at 32 bits
    applyStimulus(1, 0, 0, 1, 0, 5'd0, 5'd0, 64'h0, 32'h0, 32'hFFFF_FFFC, 0);
    step();
    checkOutput("jal wrap", 5'd31, 64'h0000_0000_0000_0004, 1, 1, 0, 1);

    // Non-writing instruction is captured without a write
    applyStimulus(1, 0, 0, 0, 0, 5'd6, 5'd0, 64'h0000_0000_0000_0123, 32'h0, 32'h0, 0);
    step();
    checkOutput("no write", 5'd6, 64'h0000_0000_0000_0123, 0, 0, 0, 1);

    // Asynchronous reset in S_LO discards the pending high word
    applyStimulus(1, 1, 0, 0, 1, 5'd20, 5'd21, 64'h5555_6666_7777_8888, 32'h0, 32'h0, 0);
    step();
    checkOutput("wide4 lo", 5'd20, 64'h0000_0000_7777_8888, 1, 0, 1, 1);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 5'd0, 64'd0, 0, 0, 0, 1);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("no hi after reset", 5'd0, 64'd0, 0, 0, 0, 0);
    step();
    checkOutput("still idle", 5'd0, 64'd0, 0, 0, 0, 0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
